// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/odd parity/stop, checks the device ACK.
// Optional PS2TX_AUTO_RETRY_EN: a failed frame is resent up to twice before error is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1920,
    parameter int TIMEOUT_CYCLES = 240000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       rx_inhibit,
    input  logic       clkps2_in,
    input  logic       dataps2_in,
    output logic       clkps2_oe,
    output logic       dataps2_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAITIDLE, S_FAIL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_clk_filt, r_clk_filt_d, r_fall;
    logic [FLT_W-1:0] r_flt_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_byte;
    logic [9:0]       r_shift;
    logic [3:0]       r_bit;
    logic             r_dbit;
    logic             w_fall, w_edge, w_timeout, w_inhibit_last;
`ifdef PS2TX_AUTO_RETRY_EN
    logic [1:0]       r_retry;
    logic             w_retry_left;
    assign w_retry_left = (r_retry != 2'd2);
`endif

    // Both synchronisers idle high so reset never fakes an edge.
    // NOTE: non-blocking assignments let every flop sample pre-edge values, so the 2-FF chain really is two stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= clkps2_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= dataps2_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_flt_cnt    <= '0;
            r_fall       <= 1'b0;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            r_fall       <= w_fall;
            if (r_clk_s2 == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER_CYCLES - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + FLT_W'(1);
            end
        end
    end

    assign w_fall         = r_clk_filt_d & ~r_clk_filt;
    assign w_edge         = r_clk_filt_d ^ r_clk_filt;
    assign w_timeout      = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_inhibit_last = (r_state == S_INHIBIT) && (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: default assignment first so no path leaves the variable unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (tx_valid) w_state_nxt = S_INHIBIT;
            S_INHIBIT:  if (w_inhibit_last) w_state_nxt = S_START;
            S_START:    w_state_nxt = w_timeout ? S_FAIL : S_SEND;
            S_SEND: begin
                if (w_timeout)                    w_state_nxt = S_FAIL;
                else if (r_fall && r_bit == 4'd9) w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (w_timeout)   w_state_nxt = S_FAIL;
                else if (r_fall) w_state_nxt = r_dat_s2 ? S_FAIL : S_WAITIDLE;
            end
            S_WAITIDLE: begin
                if (r_clk_filt && r_dat_s2) w_state_nxt = S_IDLE;
                else if (w_timeout)         w_state_nxt = S_FAIL;
            end
`ifdef PS2TX_AUTO_RETRY_EN
            S_FAIL:     w_state_nxt = w_retry_left ? S_INHIBIT : S_IDLE;
`else
            S_FAIL:     w_state_nxt = S_IDLE;
`endif
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_ready   = (r_state == S_IDLE);
        busy       = (r_state != S_IDLE);
        rx_inhibit = busy;
        clkps2_oe  = (r_state == S_INHIBIT);
        dataps2_oe = w_inhibit_last || (r_state == S_START) || ((r_state == S_SEND) && !r_dbit);
        done       = (r_state == S_WAITIDLE) && r_clk_filt && r_dat_s2;
`ifdef PS2TX_AUTO_RETRY_EN
        error      = (r_state == S_FAIL) && !w_retry_left;
`else
        error      = (r_state == S_FAIL);
`endif
    end

    // Shared counter: INHIBIT hold time, then inter-edge timeout; edges seen while inhibiting are our own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (r_state != S_INHIBIT && w_edge) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte  <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_dbit  <= 1'b1;
        end else begin
            if (r_state == S_IDLE && tx_valid) r_byte <= tx_data;
            if (r_state == S_START) begin
                r_shift <= {1'b1, ~^r_byte, r_byte};
                r_bit   <= '0;
                r_dbit  <= 1'b0;
            end else if (r_state == S_SEND && r_fall) begin
                r_dbit  <= r_shift[0];
                r_shift <= {1'b0, r_shift[9:1]};
                r_bit   <= r_bit + 4'd1;
            end
        end
    end

`ifdef PS2TX_AUTO_RETRY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                            r_retry <= '0;
        else if (r_state == S_IDLE && tx_valid) r_retry <= '0;
        else if (r_state == S_FAIL && w_retry_left) r_retry <= r_retry + 2'd1;
    end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain device model, table of frames plus timeout, busy, reset-in-frame sequences.
// Timeout is shortened to keep the run short; inhibit and filter lengths keep their defaults.
module tb_ps2_host_tx;

    localparam int INHIBIT    = 1920;
    localparam int TB_TIMEOUT = 2500;
`ifdef PS2TX_AUTO_RETRY_EN
    localparam int FAIL_ATTEMPTS = 3;
`else
    localparam int FAIL_ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, error, rx_inhibit;
    logic       clkps2_in, dataps2_in, clkps2_oe, dataps2_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    assign clkps2_in  = dev_clk & ~clkps2_oe;
    assign dataps2_in = dev_data & ~dataps2_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TB_TIMEOUT),
        .FILTER_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .rx_inhibit(rx_inhibit),
        .clkps2_in (clkps2_in),
        .dataps2_in(dataps2_in),
        .clkps2_oe (clkps2_oe),
        .dataps2_oe(dataps2_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mon_done = 0, mon_err = 0, mon_both = 0, mon_inh = 0, mon_oe_hi = 0;
    int mon_rxinh_bad = 0, mon_ready_bad = 0;
    logic prev_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) mon_done <= mon_done + 1;
        if (error === 1'b1) mon_err <= mon_err + 1;
        if (done === 1'b1 && error === 1'b1) mon_both <= mon_both + 1;
        if (clkps2_oe === 1'b1) mon_oe_hi <= mon_oe_hi + 1;
        if (clkps2_oe === 1'b1 && prev_oe !== 1'b1) mon_inh <= mon_inh + 1;
        if (rx_inhibit !== busy) mon_rxinh_bad <= mon_rxinh_bad + 1;
        if (tx_ready !== !busy) mon_ready_bad <= mon_ready_bad + 1;
        prev_oe <= clkps2_oe;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic request(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_oe(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (clkps2_oe === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device model: waits for the host to release the clock, then clocks 11 edges; returns line level after edges 1..10.
    task automatic device_frame(input int half, input bit ack, input int glitch_at, input int reset_at,
                                output logic [9:0] bits, output int attempts);
        bit ok;
        bit finished;
        bits     = '0;
        attempts = 0;
        for (int a = 0; a < 4; a++) begin
            wait_oe(1'b1, 4000, ok);
            check("inhibit_start_seen", 32'(ok), 1);
            if (!ok) return;
            attempts++;
            wait_oe(1'b0, 4000, ok);
            check("inhibit_end_seen", 32'(ok), 1);
            if (!ok) return;
            repeat (20) @(negedge clk);
            for (int k = 1; k <= 11; k++) begin
                if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
                dev_clk = 1'b0;
                repeat (half - 2) @(negedge clk);
                if (k <= 10) bits[k-1] = dataps2_in;
                if (k == reset_at) begin
                    check("pre_reset_data_driven", 32'(dataps2_oe), 1);
                    rst_n = 1'b0;
                    @(posedge clk);
                    #1;
                    check("rst_mid_clk_oe", 32'(clkps2_oe), 0);
                    check("rst_mid_data_oe", 32'(dataps2_oe), 0);
                    check("rst_mid_tx_ready", 32'(tx_ready), 1);
                    check("rst_mid_busy", 32'(busy), 0);
                    rst_n = 1'b1;
                end
                repeat (2) @(negedge clk);
                dev_clk = 1'b1;
                if (k == glitch_at) begin
                    repeat (15) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (3) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (half - 18) @(negedge clk);
                end else begin
                    repeat (half) @(negedge clk);
                end
                dev_data = 1'b1;
            end
            finished = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (busy === 1'b0) begin
                    finished = 1'b1;
                    break;
                end
                if (clkps2_oe === 1'b1) break;
            end
            if (finished) return;
        end
        check("frame_terminated", 32'(attempts), 32'(FAIL_ATTEMPTS));
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         half;
        int         glitch_at;
        logic [9:0] exp_bits;
        int         exp_done;
        int         exp_err;
        int         exp_att;
    } vec_t;

    vec_t       vecs[5];
    logic [9:0] bits;
    int         att, s_done, s_err, s_inh, s_hi, ready_hi;
    bit         ok, got_err;
    int         t0, t_err;
    logic [1:0] oe_at_err;

    initial begin
        vecs[0] = '{8'hED, 1'b1, 640, 0, 10'h3ED, 1, 0, 1};
        vecs[1] = '{8'hF4, 1'b1, 40,  0, 10'h2F4, 1, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 40,  0, 10'h300, 1, 0, 1};
        vecs[3] = '{8'h01, 1'b1, 40,  4, 10'h201, 1, 0, 1};
        vecs[4] = '{8'hFF, 1'b0, 40,  0, 10'h3FF, 0, 1, FAIL_ATTEMPTS};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_ready", 32'(tx_ready), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_rx_inhibit", 32'(rx_inhibit), 0);
        check("reset_clk_oe", 32'(clkps2_oe), 0);
        check("reset_data_oe", 32'(dataps2_oe), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            s_done = mon_done; s_err = mon_err; s_inh = mon_inh; s_hi = mon_oe_hi;
            request(vecs[v].data);
            device_frame(vecs[v].half, vecs[v].ack, vecs[v].glitch_at, 0, bits, att);
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_bits", v), 32'(bits), 32'(vecs[v].exp_bits));
            check($sformatf("v%0d_done", v), 32'(mon_done - s_done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_error", v), 32'(mon_err - s_err), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_attempts", v), 32'(mon_inh - s_inh), 32'(vecs[v].exp_att));
            check($sformatf("v%0d_inhibit_cycles", v), 32'(mon_oe_hi - s_hi), 32'(INHIBIT * vecs[v].exp_att));
            check($sformatf("v%0d_idle_ready", v), 32'({tx_ready, busy, clkps2_oe, dataps2_oe}), 32'(4'b1000));
        end

        // Device never clocks: error after the inter-edge timeout, lines released.
        s_done = mon_done; s_err = mon_err; s_inh = mon_inh;
        got_err = 1'b0; att = 0; t0 = 0; t_err = 0; oe_at_err = 2'b11;
        request(8'hF4);
        for (int a = 0; a < 4; a++) begin
            wait_oe(1'b1, 4000, ok);
            if (!ok) break;
            att++;
            wait_oe(1'b0, 4000, ok);
            if (!ok) break;
            t0 = cyc;
            for (int i = 0; i < TB_TIMEOUT + 200; i++) begin
                @(negedge clk);
                if (error === 1'b1) begin
                    got_err   = 1'b1;
                    t_err     = cyc;
                    oe_at_err = {clkps2_oe, dataps2_oe};
                    break;
                end
                if (clkps2_oe === 1'b1) break;
            end
            if (got_err) break;
        end
        repeat (5) @(negedge clk);
        check("to_error_seen", 32'(got_err), 1);
        check("to_window", 32'((t_err - t0) >= TB_TIMEOUT && (t_err - t0) <= TB_TIMEOUT + 40), 1);
        check("to_oe_released", 32'(oe_at_err), 0);
        check("to_attempts", 32'(att), 32'(FAIL_ATTEMPTS));
        check("to_error_count", 32'(mon_err - s_err), 1);
        check("to_no_done", 32'(mon_done - s_done), 0);

        // Request while busy is ignored and never queued.
        s_done = mon_done; s_inh = mon_inh; ready_hi = 0;
        request(8'hFF);
        fork
            device_frame(40, 1'b1, 0, 0, bits, att);
            begin
                repeat (2500) @(negedge clk);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                repeat (40) begin
                    @(negedge clk);
                    if (tx_ready === 1'b1) ready_hi++;
                end
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        join
        repeat (3000) @(negedge clk);
        check("busy_bits", 32'(bits), 32'(10'h3FF));
        check("busy_ready_low", 32'(ready_hi), 0);
        check("busy_done", 32'(mon_done - s_done), 1);
        check("busy_no_second_frame", 32'(mon_inh - s_inh), 1);

        // Reset asserted during edge 5 of a frame.
        s_done = mon_done; s_err = mon_err;
        request(8'hED);
        device_frame(40, 1'b1, 0, 5, bits, att);
        repeat (20) @(negedge clk);
        check("rst_first_bits", 32'(bits[3:0]), 32'(4'hD));
        check("rst_no_done", 32'(mon_done - s_done), 0);
        check("rst_no_error", 32'(mon_err - s_err), 0);

        check("done_error_overlap", 32'(mon_both), 0);
        check("rx_inhibit_eq_busy", 32'(mon_rxinh_bad), 0);
        check("tx_ready_eq_not_busy", 32'(mon_ready_bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
